// File: rtl/qos_pkg.sv
// qos_pkg: definitions shared by the QoS arbiter and the grant-side responder.
//   NUM_VC      - number of virtual channels
//   vc_e        - VC index encodings VC0..VC3
//   arb_mode_e  - arbiter mode encodings (shared with the arbiter)
//   is_onehot() - true when exactly one bit of a grant vector is set
package qos_pkg;

  localparam int NUM_VC = 4;

  typedef enum logic [1:0] {
    VC0 = 2'd0,
    VC1 = 2'd1,
    VC2 = 2'd2,
    VC3 = 2'd3
  } vc_e;

  typedef enum logic [1:0] {
    RR   = 2'b00,
    OFF  = 2'b01,
    WRR  = 2'b10,
    OFF2 = 2'b11
  } arb_mode_e;

  // v & (v-1) clears the lowest set bit; a one-hot vector becomes zero.
  function automatic logic is_onehot(input logic [NUM_VC-1:0] v);
    return (v != '0) && ((v & (v - NUM_VC'(1))) == '0);
  endfunction

endpackage

// File: rtl/qos_vc_fifo.sv
// qos_vc_fifo: single virtual-channel FIFO with an occupancy count.
// A push is accepted when the FIFO is not full, or when a pop happens in
// the same cycle (the freed slot is reused). A refused push raises drop.
// Ports:
//   clk, reset_L      clock, async active-low reset
//   push, push_data   write request and data (already qualified by enable/VC)
//   pop               read request (already qualified by grant decode)
//   rd_data           entry at the read pointer (valid while count > 0)
//   count             occupancy 0..DEPTH
//   drop              push refused this cycle (combinational)
module qos_vc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              drop
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qos_vc_queue_responder.sv
// qos_vc_queue_responder: grant-side responder for the QoS arbiter.
// Buffers packets for NUM_VC virtual channels and pops the VC selected by
// the arbiter's one-hot grant onto a registered egress stream (1-cycle
// grant-to-data latency, one pop per cycle).
// Ports:
//   clk, reset_L        clock, async active-low reset
//   enb                 block enable; 0 = no push, no pop
//   push/push_vc/push_data  write request from the classifier
//   grant               one-hot grant from the arbiter
//   pop_data/pop_vc/pop_valid  registered egress; data/vc hold when not valid
//   empty, full         per-VC status, combinational from counts
//   gnt_miss            1-cycle pulse: one-hot grant to an empty VC
//   gnt_err             1-cycle pulse: multi-hot grant
//   ovf                 sticky per-VC overflow (push dropped)
//   almost_full         per-VC count >= AF_TH (only with QOS_RESP_ALMOST_FULL_EN)
// Build option: define QOS_RESP_ALMOST_FULL_EN to add the almost_full port.
module qos_vc_queue_responder
  import qos_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enb,
  input  logic              push,
  input  logic [1:0]        push_vc,
  input  logic [DATA_W-1:0] push_data,
  input  logic [NUM_VC-1:0] grant,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [1:0]        pop_vc,
  output logic [NUM_VC-1:0] empty,
  output logic [NUM_VC-1:0] full,
  output logic              gnt_miss,
  output logic              gnt_err,
  output logic [NUM_VC-1:0] ovf
`ifdef QOS_RESP_ALMOST_FULL_EN
  ,
  output logic [NUM_VC-1:0] almost_full
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rd_data [NUM_VC];
  logic [CW-1:0]     count   [NUM_VC];
  logic [NUM_VC-1:0] push_sel;
  logic [NUM_VC-1:0] pop_sel;
  logic [NUM_VC-1:0] drop;
  logic [1:0]        gnt_idx;
  logic              gnt_onehot;
  logic              pop_any;
  logic              miss_now;
  logic              err_now;

  assign gnt_onehot = is_onehot(grant);

  always_comb begin
    gnt_idx = VC0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (grant[i]) gnt_idx = 2'(i);
    end
  end

  // Pops only on a clean one-hot grant to a non-empty VC; a push arriving in
  // the same cycle to an empty VC cannot be bypassed, so the grant misses.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      pop_sel[i]  = enb & gnt_onehot & grant[i] & ~empty[i];
      push_sel[i] = enb & push & (push_vc == 2'(i));
    end
  end

  assign pop_any  = |pop_sel;
  assign miss_now = enb & gnt_onehot & empty[gnt_idx];
  assign err_now  = enb & (grant != '0) & ~gnt_onehot;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    qos_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_L   (reset_L),
      .push      (push_sel[g]),
      .push_data (push_data),
      .pop       (pop_sel[g]),
      .rd_data   (rd_data[g]),
      .count     (count[g]),
      .drop      (drop[g])
    );

    assign empty[g] = (count[g] == '0);
    assign full[g]  = (count[g] == CW'(DEPTH));
`ifdef QOS_RESP_ALMOST_FULL_EN
    assign almost_full[g] = (count[g] >= CW'(AF_TH));
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_data  <= '0;
      pop_vc    <= VC0;
      pop_valid <= 1'b0;
      gnt_miss  <= 1'b0;
      gnt_err   <= 1'b0;
      ovf       <= '0;
    end else begin
      pop_valid <= pop_any;
      gnt_miss  <= miss_now;
      gnt_err   <= err_now;
      ovf       <= ovf | drop;
      if (pop_any) begin
        pop_data <= rd_data[gnt_idx];
        pop_vc   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_qos_vc_queue_responder.sv
module tb_qos_vc_queue_responder;
  import qos_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF_TH  = 3;

  logic              clk;
  logic              reset_L;
  logic              enb;
  logic              push;
  logic [1:0]        push_vc;
  logic [DATA_W-1:0] push_data;
  logic [3:0]        grant;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [1:0]        pop_vc;
  logic [3:0]        empty;
  logic [3:0]        full;
  logic              gnt_miss;
  logic              gnt_err;
  logic [3:0]        ovf;
`ifdef QOS_RESP_ALMOST_FULL_EN
  logic [3:0]        almost_full;
`endif

  qos_vc_queue_responder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_TH  (AF_TH)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .enb       (enb),
    .push      (push),
    .push_vc   (push_vc),
    .push_data (push_data),
    .grant     (grant),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .pop_vc    (pop_vc),
    .empty     (empty),
    .full      (full),
    .gnt_miss  (gnt_miss),
    .gnt_err   (gnt_err),
    .ovf       (ovf)
`ifdef QOS_RESP_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miscompare;

  // Reference model: one queue per VC, plus scoreboard of expected egress.
  logic [7:0]  mq [4][$];
  logic [9:0]  sb [$];          // {vc, data}
  logic [3:0]  m_ovf;
  logic [7:0]  last_data;
  logic [1:0]  last_vc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_empty();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() == 0);
    return r;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() == DEPTH);
    return r;
  endfunction

`ifdef QOS_RESP_ALMOST_FULL_EN
  function automatic logic [3:0] m_af();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() >= AF_TH);
    return r;
  endfunction
`endif

  task automatic check_status();
    chk("empty", 32'(empty), 32'(m_empty()));
    chk("full",  32'(full),  32'(m_full()));
    chk("ovf",   32'(ovf),   32'(m_ovf));
`ifdef QOS_RESP_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full), 32'(m_af()));
`endif
  endtask

  // Drive one cycle of stimulus, advance the model, then check the outputs
  // produced by that clock edge.
  task automatic step(input logic e, input logic p, input logic [1:0] v,
                      input logic [7:0] d, input logic [3:0] g);
    logic exp_pv, exp_miss, exp_err;
    int   idx;
    logic [9:0] ent;
    enb = e; push = p; push_vc = v; push_data = d; grant = g;
    exp_pv = 0; exp_miss = 0; exp_err = 0; idx = 0;
    if (e) begin
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      if (g != 0 && $countones(g) != 1) exp_err = 1;
      else if (g != 0) begin
        if (mq[idx].size() > 0) begin
          last_data = mq[idx].pop_front();
          last_vc   = 2'(idx);
          sb.push_back({last_vc, last_data});
          exp_pv = 1;
        end else exp_miss = 1;
      end
      if (p) begin
        if (mq[v].size() < DEPTH) mq[v].push_back(d);
        else m_ovf[v] = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
    chk("gnt_miss",  32'(gnt_miss),  32'(exp_miss));
    chk("gnt_err",   32'(gnt_err),   32'(exp_err));
    if (pop_valid && sb.size() > 0) begin
      ent = sb.pop_front();
      chk("pop_data", 32'(pop_data), 32'(ent[7:0]));
      chk("pop_vc",   32'(pop_vc),   32'(ent[9:8]));
    end else begin
      chk("pop_data_hold", 32'(pop_data), 32'(last_data));
      chk("pop_vc_hold",   32'(pop_vc),   32'(last_vc));
    end
    check_status();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    sb.delete();
    m_ovf = '0; last_data = '0; last_vc = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_pop_data",  32'(pop_data),  0);
    chk("rst_pop_vc",    32'(pop_vc),    0);
    chk("rst_gnt_miss",  32'(gnt_miss),  0);
    chk("rst_gnt_err",   32'(gnt_err),   0);
    chk("rst_empty",     32'(empty),     32'hF);
    chk("rst_full",      32'(full),      0);
    chk("rst_ovf",       32'(ovf),       0);
  endtask

  initial begin
    n_vec = 0; n_miscompare = 0;
    model_reset();
    enb = 0; push = 0; push_vc = 0; push_data = 0; grant = 0;
    reset_L = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_L = 1'b1;

    // 1: VC2 push two, grant twice
    step(1, 1, 2, 8'hA1, 4'b0000);
    step(1, 1, 2, 8'hA2, 4'b0000);
    step(1, 0, 0, 8'h00, 4'b0100);
    step(1, 0, 0, 8'h00, 4'b0100);

    // 2: fill VC0, overflow with no grant, drain
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 8'hB0 + 8'(i), 4'b0000);
    step(1, 1, 0, 8'hBF, 4'b0000);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'h00, 4'b0001);
    // refill, then push while popping a full VC
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 8'hC0 + 8'(i), 4'b0000);
    step(1, 1, 0, 8'hCF, 4'b0001);

    // 3: miss on empty VC3, multi-hot error
    step(1, 0, 0, 8'h00, 4'b1000);
    step(1, 1, 1, 8'hD1, 4'b0011);
    step(1, 0, 0, 8'h00, 4'b0010);
    // push to empty VC3 with same-cycle grant: miss, data stored
    step(1, 1, 3, 8'hE3, 4'b1000);
    step(1, 0, 0, 8'h00, 4'b1000);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'h00, 4'b0001);

    // 4: one entry per VC, back-to-back grants
    for (int i = 0; i < 4; i++) step(1, 1, 2'(i), 8'h10 * 8'(i + 1), 4'b0000);
    step(1, 0, 0, 8'h00, 4'b0001);
    step(1, 0, 0, 8'h00, 4'b0010);
    step(1, 0, 0, 8'h00, 4'b0100);
    step(1, 0, 0, 8'h00, 4'b1000);

`ifdef QOS_RESP_ALMOST_FULL_EN
    // 6: almost_full threshold on VC1
    step(1, 1, 1, 8'h61, 4'b0000);
    step(1, 1, 1, 8'h62, 4'b0000);
    step(1, 1, 1, 8'h63, 4'b0000);
    step(1, 0, 0, 8'h00, 4'b0010);
    step(1, 0, 0, 8'h00, 4'b0010);
    step(1, 0, 0, 8'h00, 4'b0010);
`endif

    // 5: enb low holds everything
    step(1, 1, 1, 8'h71, 4'b0000);
    step(1, 1, 1, 8'h72, 4'b0000);
    step(0, 1, 1, 8'h73, 4'b0010);
    step(0, 1, 1, 8'h74, 4'b0011);
    step(0, 1, 0, 8'h75, 4'b0001);
    step(1, 1, 1, 8'h76, 4'b0010);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 1, 8'h80 + 8'(i), 4'b0000);
    // async reset in the middle of a cycle
    #3;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk); #1;
    reset_L = 1'b1;
    enb = 0; push = 0; grant = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] g;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2)      g = 4'b0000;
      else if (sel < 9) g = 4'b0001 << $urandom_range(0, 3);
      else              g = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/qos_vc_queue_responder.md
Name: qos_vc_queue_responder

Overview:
- Grant-side responder for the QoS round-robin/weighted arbiter. It buffers packets for 4 virtual channels (VC0-VC3) in per-VC FIFOs.
- It consumes the arbiter's 4-bit one-hot grant and pops the granted VC onto a single egress stream.
- It returns per-VC empty/full status so the arbiter and upstream classifier can gate requests.
- Sits between the TLP classifier (push side) and the PCIe egress link (pop side).

Parameters:
- DATA_W, 8, width of one queued data word.
- DEPTH, 4, entries per VC FIFO; must be a power of 2, minimum 2.
- AF_TH, 3, almost-full threshold in entries; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- enb  in  1  block enable; when 0, no push or pop is performed.
- push  in  1  write request.
- push_vc  in  2  target VC index of the write.
- push_data  in  DATA_W  write data.
- grant  in  4  one-hot grant from the arbiter (bit i = VCi).
- pop_data  out  DATA_W  egress data, registered.
- pop_valid  out  1  pop_data is valid this cycle.
- pop_vc  out  2  VC index of pop_data.
- empty  out  4  per-VC empty flags.
- full  out  4  per-VC full flags.
- gnt_miss  out  1  one-cycle pulse: valid grant to an empty VC.
- gnt_err  out  1  one-cycle pulse: grant is multi-hot.
- ovf  out  4  sticky per-VC overflow flags (push dropped).

Behaviour:
- Reset (async, reset_L=0): all FIFO pointers and counts go to 0. Outputs: pop_data=0, pop_valid=0, pop_vc=0, empty=4'b1111, full=0, gnt_miss=0, gnt_err=0, ovf=0. Asserting reset mid-operation discards all queued data immediately.
- Counts: each VC keeps wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits ranging 0..DEPTH.
- Flags: empty[i] = (count_i==0); full[i] = (count_i==DEPTH). Both are combinational from the registered counts.
- Pop is evaluated at posedge with enb=1:
  - grant==0: idle; pop_valid=0 next cycle.
  - grant one-hot at bit i and count_i>0: read the entry at rd_ptr_i and advance rd_ptr_i. Next cycle pop_data=entry, pop_vc=i, pop_valid=1. Latency is 1 cycle grant-to-data, and one pop per cycle gives full throughput.
  - grant one-hot at bit i and count_i==0: no pop; pop_valid=0; gnt_miss=1 for one cycle.
  - grant multi-hot: no pop; pop_valid=0; gnt_err=1 for one cycle. This rule takes precedence over the miss rule.
- Push is evaluated at posedge with enb=1 and push=1, targeting VC q=push_vc:
  - Accepted if count_q<DEPTH, or if VC q is popped in the same cycle (the freed slot is reused).
  - Otherwise the push is dropped, ovf[q] is set and stays set until reset, and FIFO contents are unchanged.
- Simultaneous push and pop on the same VC: count is unchanged and both pointers advance.
- Push to an empty VC with a same-cycle grant to that VC: the grant is a miss (no bypass) and the push is stored. The data pops no earlier than the next grant.
- enb=0:
  - No push, no pop.
  - pop_valid=0 next cycle; pop_data and pop_vc hold their values.
  - gnt_miss and gnt_err stay 0.
  - FIFO contents, pointers and ovf are held.
- pop_data and pop_vc hold their last values while pop_valid=0.
- Ordering: FIFO order is strict within a VC. There are no ordering guarantees across VCs beyond grant order.

Optional Feature:
- Macro QOS_RESP_ALMOST_FULL_EN.
- When defined: adds output port almost_full, in/out out, width 4, with almost_full[i] = (count_i >= AF_TH). It is combinational from the counts and 0 at reset. AF_TH must satisfy 1..DEPTH.
- When undefined: the port and its logic are absent, and AF_TH is unused.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package qos_pkg holds:
  - NUM_VC=4.
  - VC index encodings VC0..VC3 = 2'd0..2'd3.
  - Arbiter mode encodings shared with the arbiter: RR=2'b00, OFF=2'b01, WRR=2'b10, OFF2=2'b11.
  - A helper function for the one-hot check.
- One natural sub-module: qos_vc_fifo (single-VC FIFO with count, empty/full and a pop-accept-aware push), instantiated NUM_VC times. The top level holds grant decode, the output register, the error pulses and the ovf flags.

Test Plan:
1. Reset, then push 8'hA1/8'hA2 to VC2 over 2 cycles, then grant=4'b0100 for 2 cycles. Expect pop_data A1 then A2, pop_vc=2, pop_valid=1 one cycle after each grant, and empty[2]=1 after the second pop.
2. Fill VC0 with DEPTH entries (expect full[0]=1), then push once more with grant=0. Expect the push dropped, ovf[0]=1 sticky, and contents unchanged on drain. Repeat with grant=4'b0001 in the same cycle: expect the push accepted and ovf unchanged.
3. Grant 4'b1000 with VC3 empty: expect gnt_miss=1 for 1 cycle, pop_valid=0, no pointer change. Grant 4'b0011: expect gnt_err=1, gnt_miss=0, no pop.
4. Load VC0..VC3 with 8'h10,8'h20,8'h30,8'h40, then apply grants 0001,0010,0100,1000 back-to-back. Expect 4 consecutive valid cycles with data 10,20,30,40 and pop_vc 0,1,2,3.
5. With VC1 holding 2 entries, drop enb to 0 for 3 cycles while driving push and grant. Expect no state change and pop_valid=0. Then assert reset_L=0 asynchronously mid-cycle: expect empty=4'b1111, ovf=0, pop_valid=0 immediately.
6. (QOS_RESP_ALMOST_FULL_EN defined, DEPTH=4, AF_TH=3) Push 3 entries to VC1: expect almost_full[1]=1 after the third push. Pop one: expect almost_full[1]=0.
